cache_array_controller: RTL and testbench

//  Controller-side responder of the arbiter/controller interface. Direct-mapped line store.

---
 rtl/cache_array_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_cache_array_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_array_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_array_controller
// Description : Controller-side responder for the arbiter/controller link.
//               Holds a direct-mapped store of NUM_LINES x 256-bit lines.
//               It answers arbiter word reads and applies byte-masked line
//               writes. When a read or a partial write misses, it raises a
//               repair request carrying the line address. It then waits for
//               the arbiter to fill the line and pulse i_repair_resolved.
//               Finally it retries the read, or merges the held write.
// Ports       : clk, rst_n                clock, async active-low reset
//               i_raddr_valid, i_raddr    word read request (word = raddr[4:2])
//               i_waddr_valid, i_waddr,   line write request
//               i_wdata, i_wmask          (all-ones mask = full line fill)
//               i_repair_resolved         arbiter finished servicing a miss
//               o_rdata, o_rdata_valid    read response (1-cycle pulse)
//               o_read_repair_request     read miss pending (level)
//               o_write_miss_repair       partial-write miss pending (level)
//               o_missed_addr             line-aligned miss address
// Revision    : 1.0 - initial release
// ============================================================================
module cache_array_controller #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_raddr_valid,
  input  logic [31:0]               i_raddr,
  input  logic                      i_waddr_valid,
  input  logic [31:0]               i_waddr,
  input  logic [LINE_BYTES*8-1:0]   i_wdata,
  input  logic [LINE_BYTES-1:0]     i_wmask,
  input  logic                      i_repair_resolved,
  output logic [31:0]               o_rdata,
  output logic                      o_rdata_valid,
  output logic                      o_read_repair_request,
  output logic                      o_write_miss_repair,
  output logic [31:0]               o_missed_addr
);

  localparam int C_INDEX_W = $clog2(NUM_LINES);
  localparam int C_TAG_W   = 32 - 5 - C_INDEX_W;
  localparam int C_LINE_W  = LINE_BYTES * 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RLOOK  = 3'd1;
  localparam logic [2:0] S_RMISS  = 3'd2;
  localparam logic [2:0] S_WMISS  = 3'd3;
  localparam logic [2:0] S_WMERGE = 3'd4;

  // Byte-enable merge of new data over an existing line.
  function automatic logic [C_LINE_W-1:0] f_merge(
    input logic [C_LINE_W-1:0]   old_line,
    input logic [C_LINE_W-1:0]   new_line,
    input logic [LINE_BYTES-1:0] mask
  );
    logic [C_LINE_W-1:0] res;
    res = old_line;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (mask[i]) res[8*i +: 8] = new_line[8*i +: 8];
    end
    return res;
  endfunction

  // Arrays
  logic [NUM_LINES-1:0] r_valid;
  logic [C_TAG_W-1:0]   r_tag  [NUM_LINES];
  logic [C_LINE_W-1:0]  r_data [NUM_LINES];

  // Control / held request state
  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [31:2]           r_raddr;
  logic [31:5]           r_hwaddr;
  logic [C_LINE_W-1:0]   r_hwdata;
  logic [LINE_BYTES-1:0] r_hwmask;
  logic [31:5]           r_missed_line;

  // Incoming write decode
  logic [C_INDEX_W-1:0] w_widx;
  logic [C_TAG_W-1:0]   w_wtag;
  logic                 w_full;
  logic                 w_w_hit;
  logic                 w_fill;
  logic                 w_part_hit;
  logic                 w_part_miss;

  // Captured read decode
  logic [C_INDEX_W-1:0] w_ridx;
  logic [C_TAG_W-1:0]   w_rtag;
  logic                 w_r_hit;
  logic [C_LINE_W-1:0]  w_rline;

  // Held write decode
  logic [C_INDEX_W-1:0] w_hidx;
  logic [C_TAG_W-1:0]   w_htag;
  logic                 w_h_hit;

  // Single array write port
  logic                 w_wr_en;
  logic                 w_wr_set_valid;
  logic [C_INDEX_W-1:0] w_wr_idx;
  logic [C_TAG_W-1:0]   w_wr_tag;
  logic [C_LINE_W-1:0]  w_wr_line;

  // Offset bits are meaningless for line writes; low read bits pick no word.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_waddr[4:0], i_raddr[1:0]};

  assign w_widx  = i_waddr[5 +: C_INDEX_W];
  assign w_wtag  = i_waddr[31 -: C_TAG_W];
  assign w_full  = &i_wmask;
  assign w_w_hit = r_valid[w_widx] && (r_tag[w_widx] == w_wtag);

  // Fills are accepted everywhere except WMERGE; partial writes only in IDLE.
  assign w_fill      = i_waddr_valid && w_full && (r_state != S_WMERGE);
  assign w_part_hit  = i_waddr_valid && !w_full && (r_state == S_IDLE) && w_w_hit;
  assign w_part_miss = i_waddr_valid && !w_full && (r_state == S_IDLE) && !w_w_hit;

  assign w_ridx  = r_raddr[5 +: C_INDEX_W];
  assign w_rtag  = r_raddr[31 -: C_TAG_W];
  assign w_r_hit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
  assign w_rline = r_data[w_ridx];

  assign w_hidx  = r_hwaddr[5 +: C_INDEX_W];
  assign w_htag  = r_hwaddr[31 -: C_TAG_W];
  assign w_h_hit = r_valid[w_hidx] && (r_tag[w_hidx] == w_htag);

  always_comb begin
    w_wr_en        = 1'b0;
    w_wr_set_valid = 1'b0;
    w_wr_idx       = w_widx;
    w_wr_tag       = w_wtag;
    w_wr_line      = i_wdata;
    if (w_fill) begin
      w_wr_en        = 1'b1;
      w_wr_set_valid = 1'b1;
    end else if (w_part_hit) begin
      w_wr_en   = 1'b1;
      w_wr_line = f_merge(r_data[w_widx], i_wdata, i_wmask);
    end else if ((r_state == S_WMERGE) && w_h_hit) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = w_hidx;
      w_wr_tag  = w_htag;
      w_wr_line = f_merge(r_data[w_hidx], r_hwdata, r_hwmask);
    end
  end

  // Tag and data arrays carry no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_data[w_wr_idx] <= w_wr_line;
      r_tag[w_wr_idx]  <= w_wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_wr_set_valid) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Request capture and miss address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr       <= '0;
      r_hwaddr      <= '0;
      r_hwdata      <= '0;
      r_hwmask      <= '0;
      r_missed_line <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_raddr_valid) begin
        r_raddr <= i_raddr[31:2];
      end
      if (w_part_miss) begin
        r_hwaddr      <= i_waddr[31:5];
        r_hwdata      <= i_wdata;
        r_hwmask      <= i_wmask;
        r_missed_line <= i_waddr[31:5];
      end else if ((r_state == S_RLOOK) && !w_r_hit) begin
        r_missed_line <= r_raddr[31:5];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state. A partial-write miss takes priority over a concurrent
  // read in IDLE; the read is dropped and the arbiter must reissue it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_part_miss)        w_state_nxt = S_WMISS;
        else if (i_raddr_valid) w_state_nxt = S_RLOOK;
      end
      S_RLOOK:  w_state_nxt = w_r_hit ? S_IDLE : S_RMISS;
      S_RMISS:  if (i_repair_resolved) w_state_nxt = S_RLOOK;
      S_WMISS:  if (i_repair_resolved) w_state_nxt = S_WMERGE;
      S_WMERGE: w_state_nxt = w_h_hit ? S_IDLE : S_WMISS;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. Everything derives from registered state, so an async reset
  // forces all outputs low immediately.
  always_comb begin
    o_rdata               = '0;
    o_rdata_valid         = 1'b0;
    o_read_repair_request = (r_state == S_RMISS);
    o_write_miss_repair   = (r_state == S_WMISS);
    o_missed_addr         = {r_missed_line, 5'b0};
    if ((r_state == S_RLOOK) && w_r_hit) begin
      o_rdata_valid = 1'b1;
      o_rdata       = w_rline[{r_raddr[4:2], 5'b0} +: 32];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_array_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_array_controller
// Description : Directed self-checking bench for cache_array_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_array_controller;

  logic         clk;
  logic         rst_n;
  logic         i_raddr_valid;
  logic [31:0]  i_raddr;
  logic         i_waddr_valid;
  logic [31:0]  i_waddr;
  logic [255:0] i_wdata;
  logic [31:0]  i_wmask;
  logic         i_repair_resolved;
  logic [31:0]  o_rdata;
  logic         o_rdata_valid;
  logic         o_read_repair_request;
  logic         o_write_miss_repair;
  logic [31:0]  o_missed_addr;

  int n_tests;
  int n_fail;

  cache_array_controller #(.NUM_LINES(16), .LINE_BYTES(32)) u_dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_raddr_valid         (i_raddr_valid),
    .i_raddr               (i_raddr),
    .i_waddr_valid         (i_waddr_valid),
    .i_waddr               (i_waddr),
    .i_wdata               (i_wdata),
    .i_wmask               (i_wmask),
    .i_repair_resolved     (i_repair_resolved),
    .o_rdata               (o_rdata),
    .o_rdata_valid         (o_rdata_valid),
    .o_read_repair_request (o_read_repair_request),
    .o_write_miss_repair   (o_write_miss_repair),
    .o_missed_addr         (o_missed_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge and
  // single-cycle strobes are cleared for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    i_raddr_valid     = 1'b0;
    i_waddr_valid     = 1'b0;
    i_repair_resolved = 1'b0;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic read_req(input logic [31:0] a);
    i_raddr_valid = 1'b1;
    i_raddr       = a;
  endtask

  task automatic write_req(input logic [31:0] a, input logic [255:0] d, input logic [31:0] m);
    i_waddr_valid = 1'b1;
    i_waddr       = a;
    i_wdata       = d;
    i_wmask       = m;
  endtask

  initial begin
    logic [255:0] line_a;
    n_tests           = 0;
    n_fail            = 0;
    rst_n             = 1'b0;
    i_raddr_valid     = 1'b0;
    i_raddr           = '0;
    i_waddr_valid     = 1'b0;
    i_waddr           = '0;
    i_wdata           = '0;
    i_wmask           = '0;
    i_repair_resolved = 1'b0;

    // Reset state
    #1;
    chk("rst_rvalid", {31'd0, o_rdata_valid}, 32'd0);
    chk("rst_rreq",   {31'd0, o_read_repair_request}, 32'd0);
    chk("rst_wreq",   {31'd0, o_write_miss_repair}, 32'd0);
    chk("rst_maddr",  o_missed_addr, 32'd0);
    #21 rst_n = 1'b1;
    tick();

    // 1: cold read misses
    read_req(32'h0000_0040);
    tick();                                   // RLOOK
    chk("t1_lookup_rvalid", {31'd0, o_rdata_valid}, 32'd0);
    tick();                                   // RMISS
    chk("t1_rreq",   {31'd0, o_read_repair_request}, 32'd1);
    chk("t1_maddr",  o_missed_addr, 32'h0000_0040);
    chk("t1_rvalid", {31'd0, o_rdata_valid}, 32'd0);
    tick();
    chk("t1_rreq_hold", {31'd0, o_read_repair_request}, 32'd1);

    // 2: fill in the same cycle as resolved -> re-lookup hits (word 0)
    line_a = make_line(32'hA0A0_0000);
    line_a[96 +: 32] = 32'hDEAD_BEEF;
    write_req(32'h0000_0040, line_a, 32'hFFFF_FFFF);
    i_repair_resolved = 1'b1;
    tick();                                   // RLOOK, hit
    chk("t2_rreq_drop", {31'd0, o_read_repair_request}, 32'd0);
    chk("t2_rvalid",    {31'd0, o_rdata_valid}, 32'd1);
    chk("t2_rdata_w0",  o_rdata, 32'hA0A0_0000);
    tick();                                   // IDLE
    chk("t2_rvalid_pulse", {31'd0, o_rdata_valid}, 32'd0);
    read_req(32'h0000_004C);
    tick();
    chk("t2_rvalid_4c", {31'd0, o_rdata_valid}, 32'd1);
    chk("t2_rdata_4c",  o_rdata, 32'hDEAD_BEEF);
    tick();

    // 3: partial hit write with concurrent read sees new data
    write_req(32'h0000_0040, {160'd0, 32'h1234_5678, 96'd0}, 32'h0000_F000);
    read_req(32'h0000_004C);
    tick();
    chk("t3_rvalid", {31'd0, o_rdata_valid}, 32'd1);
    chk("t3_rdata",  o_rdata, 32'h1234_5678);
    tick();
    read_req(32'h0000_0048);
    tick();
    chk("t3_w2_kept", o_rdata, 32'hA0A0_0002);
    tick();
    read_req(32'h0000_005C);
    tick();
    chk("t3_w7_kept", o_rdata, 32'hA0A0_0007);
    tick();

    // 4: partial write miss on aliased line, fill, merge, eviction
    write_req(32'h0000_0240, {224'd0, 32'hCAFE_F00D}, 32'h0000_000F);
    tick();                                   // WMISS
    chk("t4_wreq",  {31'd0, o_write_miss_repair}, 32'd1);
    chk("t4_maddr", o_missed_addr, 32'h0000_0240);
    chk("t4_rreq",  {31'd0, o_read_repair_request}, 32'd0);
    tick();
    chk("t4_wreq_hold", {31'd0, o_write_miss_repair}, 32'd1);
    write_req(32'h0000_0240, make_line(32'hB0B0_0000), 32'hFFFF_FFFF);
    i_repair_resolved = 1'b1;
    tick();                                   // WMERGE
    chk("t4_wreq_drop", {31'd0, o_write_miss_repair}, 32'd0);
    tick();                                   // IDLE
    chk("t4_wreq_done", {31'd0, o_write_miss_repair}, 32'd0);
    read_req(32'h0000_0240);
    tick();
    chk("t4_merged_rvalid", {31'd0, o_rdata_valid}, 32'd1);
    chk("t4_merged_w0",     o_rdata, 32'hCAFE_F00D);
    tick();
    read_req(32'h0000_0244);
    tick();
    chk("t4_fill_w1", o_rdata, 32'hB0B0_0001);
    tick();
    read_req(32'h0000_004C);
    tick();
    chk("t4_evict_rvalid", {31'd0, o_rdata_valid}, 32'd0);
    tick();                                   // RMISS
    chk("t4_evict_rreq",  {31'd0, o_read_repair_request}, 32'd1);
    chk("t4_evict_maddr", o_missed_addr, 32'h0000_0040);

    // 5: resolved without fill -> drop for one cycle then re-assert
    i_repair_resolved = 1'b1;
    tick();                                   // RLOOK, still miss
    chk("t5_drop",   {31'd0, o_read_repair_request}, 32'd0);
    chk("t5_no_data", {31'd0, o_rdata_valid}, 32'd0);
    tick();                                   // RMISS again
    chk("t5_reassert", {31'd0, o_read_repair_request}, 32'd1);
    chk("t5_maddr",    o_missed_addr, 32'h0000_0040);

    // 6: async reset during RMISS
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rreq_rst",  {31'd0, o_read_repair_request}, 32'd0);
    chk("t6_maddr_rst", o_missed_addr, 32'd0);
    chk("t6_rvalid_rst", {31'd0, o_rdata_valid}, 32'd0);
    #10 rst_n = 1'b1;
    tick();
    read_req(32'h0000_0240);
    tick();
    chk("t6_post_miss", {31'd0, o_rdata_valid}, 32'd0);
    tick();
    chk("t6_post_rreq",  {31'd0, o_read_repair_request}, 32'd1);
    chk("t6_post_maddr", o_missed_addr, 32'h0000_0240);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
